// File: rtl/auto_player.sv
`default_nettype none
// ============================================================================
// Module      : auto_player
// Description : Autoplayer for the LED ping-pong game. It starts a game,
//               follows the ball and presses CHANGE near the walls.
// Revision    : 1.0 - initial release
// ============================================================================
module auto_player #(
    parameter int PRESS_CYC = 50000,
    parameter int GAP_CYC   = 50000,
    parameter int MARGIN    = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [17:0] LEDR,
    output logic        ENTER_N,
    output logic        CHANGE_N,
    output logic        STOP_N,
    output logic        ACTIVE,
    output logic [7:0]  PRESSES
);

    localparam logic [17:0] START_PATTERN = 18'h20201;
    localparam logic [19:0] PRESS_LOAD    = 20'(PRESS_CYC - 1);
    localparam logic [19:0] GAP_LOAD      = 20'(GAP_CYC - 1);
    localparam logic [3:0]  TOP_POS       = 4'(15 - MARGIN);
    localparam logic [3:0]  BOT_POS       = 4'(MARGIN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_TRACK = 3'd2,
        S_PRESS = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DIR_UNKNOWN = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2
    } dir_t;

    state_t      state;
    state_t      state_nxt;
    dir_t        dir;
    dir_t        dir_nxt;
    logic [17:0] led_q;
    logic [3:0]  pos;
    logic [3:0]  last_pos;
    logic        known;
    logic        armed;
    logic        armed_nxt;
    logic        pos_valid;
    logic        moved;
    logic        press_req;
    logic        game_over;
    logic        new_game;
    logic        start_entry;
    logic        press_entry;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;

    always_comb begin
        pos = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (led_q[i+1]) begin
                pos = 4'(i);
            end
        end
        pos_valid = $onehot(led_q[16:1]);
    end

    // Ball tracking runs in every state so direction is already known when a
    // press window opens; 5-bit compares keep 15->0 from reading as a step.
    always_comb begin
        moved   = pos_valid && (!known || (pos != last_pos));
        dir_nxt = dir;
        if (moved) begin
            if (known && ({1'b0, pos} == {1'b0, last_pos} + 5'd1)) begin
                dir_nxt = DIR_UP;
            end else if (known && ({1'b0, pos} + 5'd1 == {1'b0, last_pos})) begin
                dir_nxt = DIR_DOWN;
            end else begin
                dir_nxt = DIR_UNKNOWN;
            end
        end
        armed_nxt = armed | moved;
        press_req = pos_valid && armed_nxt &&
                    (((pos == TOP_POS) && (dir_nxt == DIR_UP)) ||
                     ((pos == BOT_POS) && (dir_nxt == DIR_DOWN)));
        game_over = led_q[1] | led_q[16];
        new_game  = (led_q == START_PATTERN);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != 20'd0) ? cnt - 20'd1 : 20'd0;
        if (!EN) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 20'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (new_game) begin
                        state_nxt = S_START;
                        cnt_nxt   = PRESS_LOAD;
                    end
                end
                S_START: begin
                    if (cnt == 20'd0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
                S_TRACK: begin
                    if (game_over) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = 20'd0;
                    end else if (press_req) begin
                        state_nxt = S_PRESS;
                        cnt_nxt   = PRESS_LOAD;
                    end
                end
                S_PRESS: begin
                    if (game_over) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = 20'd0;
                    end else if (cnt == 20'd0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
                S_GAP: begin
                    if (game_over) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = 20'd0;
                    end else if (cnt == 20'd0) begin
                        state_nxt = S_TRACK;
                    end
                end
                S_DONE: begin
                    if (new_game) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 20'd0;
                end
            endcase
        end
        start_entry = (state != S_START) && (state_nxt == S_START);
        press_entry = (state != S_PRESS) && (state_nxt == S_PRESS);
    end

    // Key outputs are registered from the next state so they never glitch.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= 20'd0;
            led_q    <= 18'd0;
            last_pos <= 4'd0;
            known    <= 1'b0;
            dir      <= DIR_UNKNOWN;
            armed    <= 1'b0;
            PRESSES  <= 8'd0;
            ENTER_N  <= 1'b1;
            CHANGE_N <= 1'b1;
            ACTIVE   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            led_q <= LEDR;
            if (pos_valid) begin
                last_pos <= pos;
                known    <= 1'b1;
            end
            dir   <= start_entry ? DIR_UNKNOWN : dir_nxt;
            armed <= press_entry ? 1'b0 : armed_nxt;
            if (start_entry) begin
                PRESSES <= 8'd0;
            end else if (press_entry && (PRESSES != 8'hFF)) begin
                PRESSES <= PRESSES + 8'd1;
            end
            ENTER_N  <= (state_nxt != S_START);
            CHANGE_N <= (state_nxt != S_PRESS);
            ACTIVE   <= (state_nxt inside {S_START, S_TRACK, S_PRESS, S_GAP});
        end
    end

    assign STOP_N = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_auto_player.sv
`default_nettype none
// Bench for auto_player: a directed vector table, multi-cycle corner cases
// and a randomized ball walk compared against a behavioural model.
module tb_auto_player;

    localparam int          PRESS_CYC = 4;
    localparam int          GAP_CYC   = 3;
    localparam int          MARGIN    = 1;
    localparam logic [17:0] START_PAT = 18'h20201;

    localparam int M_IDLE   = 0;
    localparam int M_ENTER  = 1;
    localparam int M_TRACK  = 2;
    localparam int M_CHANGE = 3;
    localparam int M_GAP    = 4;
    localparam int M_OVER   = 5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        EN = 1'b0;
    logic [17:0] LEDR = 18'd0;
    logic        ENTER_N;
    logic        CHANGE_N;
    logic        STOP_N;
    logic        ACTIVE;
    logic [7:0]  PRESSES;

    auto_player #(
        .PRESS_CYC(PRESS_CYC),
        .GAP_CYC  (GAP_CYC),
        .MARGIN   (MARGIN)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (EN),
        .LEDR    (LEDR),
        .ENTER_N (ENTER_N),
        .CHANGE_N(CHANGE_N),
        .STOP_N  (STOP_N),
        .ACTIVE  (ACTIVE),
        .PRESSES (PRESSES)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        en;
        logic [17:0] ledr;
        logic        enter_n;
        logic        change_n;
        logic        active;
        logic [7:0]  presses;
    } vec_t;

    vec_t vecs[$];

    // Reference model: game phase with absolute deadlines, ball as integers.
    int          m_mode;
    int          m_deadline;
    int          m_cyc;
    int          m_presses;
    int          m_dir;
    int          m_last;
    bit          m_armed;
    logic [17:0] m_led;

    int  ball_b;
    bit  en_r;
    int  falls;
    logic prev_change;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [17:0] ball(input int b);
        logic [17:0] v;
        v    = 18'h20001;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic add_vec(input logic en, input logic [17:0] ledr, input logic e,
                           input logic c, input logic a, input logic [7:0] p);
        vec_t v;
        v.en = en; v.ledr = ledr; v.enter_n = e; v.change_n = c; v.active = a; v.presses = p;
        vecs.push_back(v);
    endtask

    task automatic wait_key(input string name, input bit change_key, input logic want, input int budget);
        int k = 0;
        while (((change_key ? CHANGE_N : ENTER_N) !== want) && (k < budget)) begin
            tick();
            k++;
        end
        check({name, " wait"}, {31'd0, (change_key ? CHANGE_N : ENTER_N)}, {31'd0, want});
    endtask

    task automatic play_to_press();
        LEDR = START_PAT;
        wait_key("game start", 1'b0, 1'b0, 10);
        for (int b = 10; b <= 15; b++) begin
            LEDR = ball(b);
            tick();
        end
        wait_key("change press", 1'b1, 1'b0, 30);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_deadline = 0; m_cyc = 0; m_presses = 0;
        m_dir = 0; m_last = -1; m_armed = 1'b0; m_led = 18'd0;
    endtask

    task automatic model_step(input logic en, input logic [17:0] ledr);
        int ones = 0;
        int p = -1;
        int nd;
        bit valid, moved, na, want, over, fresh;
        for (int i = 1; i <= 16; i++) begin
            if (m_led[i]) begin
                ones++;
                p = i - 1;
            end
        end
        valid = (ones == 1);
        moved = valid && ((m_last < 0) || (p != m_last));
        nd    = m_dir;
        if (moved) begin
            if ((m_last >= 0) && (p - m_last == 1)) nd = 1;
            else if ((m_last >= 0) && (p - m_last == -1)) nd = -1;
            else nd = 0;
        end
        na    = m_armed || moved;
        want  = valid && na && (((p == 15 - MARGIN) && (nd == 1)) || ((p == MARGIN) && (nd == -1)));
        over  = m_led[1] || m_led[16];
        fresh = (m_led == START_PAT);
        if (!en) begin
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: if (fresh) begin
                    m_mode = M_ENTER; m_deadline = m_cyc + PRESS_CYC; m_presses = 0; nd = 0;
                end
                M_ENTER: if (m_cyc == m_deadline) begin
                    m_mode = M_GAP; m_deadline = m_cyc + GAP_CYC;
                end
                M_TRACK: if (over) m_mode = M_OVER;
                    else if (want) begin
                        m_mode = M_CHANGE; m_deadline = m_cyc + PRESS_CYC; na = 1'b0;
                        m_presses = (m_presses < 255) ? m_presses + 1 : 255;
                    end
                M_CHANGE: if (over) m_mode = M_OVER;
                    else if (m_cyc == m_deadline) begin
                        m_mode = M_GAP; m_deadline = m_cyc + GAP_CYC;
                    end
                M_GAP: if (over) m_mode = M_OVER;
                    else if (m_cyc == m_deadline) m_mode = M_TRACK;
                default: if (fresh) m_mode = M_IDLE;
            endcase
        end
        m_dir   = nd;
        m_armed = na;
        if (valid) m_last = p;
        m_led = ledr;
        m_cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("reset enter_n", {31'd0, ENTER_N}, 1);
        check("reset change_n", {31'd0, CHANGE_N}, 1);
        check("reset stop_n", {31'd0, STOP_N}, 1);
        check("reset active", {31'd0, ACTIVE}, 0);
        check("reset presses", {24'd0, PRESSES}, 0);
        RESET = 1'b1;
        tick();

        // Game start and one press near the top wall
        add_vec(1'b1, START_PAT, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 4; i++) add_vec(1'b1, START_PAT, 1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 5; i <= 8; i++) add_vec(1'b1, START_PAT, 1'b1, 1'b1, 1'b1, 8'd0);
        for (int b = 10; b <= 15; b++) add_vec(1'b1, ball(b), 1'b1, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) add_vec(1'b1, ball(15), 1'b1, 1'b0, 1'b1, 8'd1);
        for (int i = 0; i < 7; i++) add_vec(1'b1, ball(15), 1'b1, 1'b1, 1'b1, 8'd1);
        foreach (vecs[i]) begin
            EN   = vecs[i].en;
            LEDR = vecs[i].ledr;
            tick();
            check($sformatf("vec%0d enter_n", i), {31'd0, ENTER_N}, {31'd0, vecs[i].enter_n});
            check($sformatf("vec%0d change_n", i), {31'd0, CHANGE_N}, {31'd0, vecs[i].change_n});
            check($sformatf("vec%0d active", i), {31'd0, ACTIVE}, {31'd0, vecs[i].active});
            check($sformatf("vec%0d presses", i), {24'd0, PRESSES}, {24'd0, vecs[i].presses});
        end

        // Ball parked at the press position: no second press
        for (int i = 0; i < 50; i++) begin
            tick();
            check("hold no repress", {31'd0, CHANGE_N}, 1);
        end
        check("hold presses", {24'd0, PRESSES}, 1);

        // Ball hits the wall, then a new game starts
        LEDR = ball(16);
        tick();
        check("wall latency active", {31'd0, ACTIVE}, 1);
        tick();
        check("done active", {31'd0, ACTIVE}, 0);
        check("done enter_n", {31'd0, ENTER_N}, 1);
        check("done change_n", {31'd0, CHANGE_N}, 1);
        LEDR = START_PAT;
        tick();
        check("done hold active", {31'd0, ACTIVE}, 0);
        tick();
        check("idle enter_n", {31'd0, ENTER_N}, 1);
        tick();
        check("restart enter_n", {31'd0, ENTER_N}, 0);
        check("restart presses", {24'd0, PRESSES}, 0);
        check("restart active", {31'd0, ACTIVE}, 1);

        // EN dropped in the second cycle of a CHANGE press
        for (int b = 10; b <= 15; b++) begin
            LEDR = ball(b);
            tick();
        end
        wait_key("en drop press", 1'b1, 1'b0, 30);
        tick();
        check("press cycle2 change_n", {31'd0, CHANGE_N}, 0);
        EN = 1'b0;
        tick();
        check("en drop change_n", {31'd0, CHANGE_N}, 1);
        check("en drop active", {31'd0, ACTIVE}, 0);
        check("en drop presses", {24'd0, PRESSES}, 1);

        // Asynchronous reset in the middle of a press
        EN = 1'b1;
        play_to_press();
        check("pre-reset presses", {24'd0, PRESSES}, 1);
        #2 RESET = 1'b0;
        #1;
        check("press reset change_n", {31'd0, CHANGE_N}, 1);
        check("press reset active", {31'd0, ACTIVE}, 0);
        check("press reset presses", {24'd0, PRESSES}, 0);
        #1 RESET = 1'b1;
        tick();

        // Asynchronous reset in the middle of GAP
        play_to_press();
        wait_key("gap entry", 1'b1, 1'b1, 10);
        tick();
        check("mid gap active", {31'd0, ACTIVE}, 1);
        check("mid gap presses", {24'd0, PRESSES}, 1);
        #2 RESET = 1'b0;
        #1;
        check("gap reset enter_n", {31'd0, ENTER_N}, 1);
        check("gap reset change_n", {31'd0, CHANGE_N}, 1);
        check("gap reset stop_n", {31'd0, STOP_N}, 1);
        check("gap reset active", {31'd0, ACTIVE}, 0);
        check("gap reset presses", {24'd0, PRESSES}, 0);
        #1 RESET = 1'b1;
        tick();

        // 300 presses saturate the counter at 255
        LEDR = START_PAT;
        for (int i = 0; i < 12; i++) tick();
        falls       = 0;
        prev_change = CHANGE_N;
        for (int i = 0; i < 300; i++) begin
            LEDR = ball(14);
            for (int k = 0; k < 2; k++) begin
                tick();
                if (prev_change && !CHANGE_N) falls++;
                prev_change = CHANGE_N;
            end
            LEDR = ball(15);
            for (int k = 0; k < 12; k++) begin
                tick();
                if (prev_change && !CHANGE_N) falls++;
                prev_change = CHANGE_N;
            end
            if (i == 253) check("presses at 254", {24'd0, PRESSES}, 254);
            if (i == 254) check("presses at 255", {24'd0, PRESSES}, 255);
        end
        check("press pulses seen", falls, 300);
        check("presses saturated", {24'd0, PRESSES}, 255);

        // Randomized ball walk against the model
        #2 RESET = 1'b0;
        EN = 1'b0;
        LEDR = 18'd0;
        model_reset();
        #2 RESET = 1'b1;
        tick();
        ball_b = 9;
        en_r   = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40) ball_b = ball_b;
            else if (r < 68) ball_b = (ball_b < 16) ? ball_b + 1 : 16;
            else if (r < 96) ball_b = (ball_b > 1) ? ball_b - 1 : 1;
            else ball_b = $urandom_range(1, 16);
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            LEDR = ball(ball_b);
            if ($urandom_range(0, 49) == 0) LEDR = 18'($urandom);
            EN = en_r;
            model_step(EN, LEDR);
            tick();
            check($sformatf("rand%0d enter_n", c), {31'd0, ENTER_N}, (m_mode == M_ENTER) ? 0 : 1);
            check($sformatf("rand%0d change_n", c), {31'd0, CHANGE_N}, (m_mode == M_CHANGE) ? 0 : 1);
            check($sformatf("rand%0d active", c), {31'd0, ACTIVE},
                  ((m_mode >= M_ENTER) && (m_mode <= M_GAP)) ? 1 : 0);
            check($sformatf("rand%0d presses", c), {24'd0, PRESSES}, m_presses);
            check($sformatf("rand%0d stop_n", c), {31'd0, STOP_N}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/auto_player.md
AUTO_PLAYER -- requirements
Module: auto_player

Interface
REQ-001 The block SHALL have parameter PRESS_CYC, default 50000, meaning the number of CLK cycles a generated key press is held low.
REQ-002 The block SHALL have parameter GAP_CYC, default 50000, meaning the minimum number of CLK cycles all keys stay high after a press.
REQ-003 The block SHALL have parameter MARGIN, default 1, meaning the distance in LEDs from a wall at which CHANGE is pressed.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port EN, input, 1 bit: autoplay enable, driven by the DEBUG switch.
REQ-007 The block SHALL have port LEDR, input, 18 bits: the game LED pattern, with walls at bits 17/0 and the ball in bits 16:1.
REQ-008 The block SHALL have port ENTER_N, output, 1 bit: active-low start key.
REQ-009 The block SHALL have port CHANGE_N, output, 1 bit: active-low direction-change key.
REQ-010 The block SHALL have port STOP_N, output, 1 bit: active-low pause key, constantly 1.
REQ-011 The block SHALL have port ACTIVE, output, 1 bit: 1 while in states START, TRACK, PRESS or GAP.
REQ-012 The block SHALL have port PRESSES, output, 8 bits: count of CHANGE presses this game, saturating at 255.

Function
REQ-013 LEDR SHALL be registered once before use, giving a one-cycle input latency.
REQ-014 The ball position SHALL be pos = index-1 of the set bit in registered LEDR[16:1] (0..15), valid only when exactly one bit is set; otherwise no action is taken.
REQ-015 Direction SHALL update on each valid position change: next = old+1 gives UP, next = old-1 gives DOWN, and any other jump gives UNKNOWN.
REQ-016 The FSM SHALL have states IDLE, START, TRACK, PRESS, GAP and DONE.
REQ-017 In IDLE, when EN=1 and registered LEDR==18'h20201, the FSM SHALL go to START, clear PRESSES, and set direction to UNKNOWN.
REQ-018 START SHALL drive ENTER_N=0 for exactly PRESS_CYC cycles, then go to GAP.
REQ-019 In TRACK, a press SHALL be requested when armed=1 and either (pos==14-MARGIN+1 and dir=UP) or (pos==MARGIN and dir=DOWN); the FSM then goes to PRESS the next cycle.
REQ-020 PRESS SHALL drive CHANGE_N=0 for exactly PRESS_CYC cycles, clear armed, and increment PRESSES (saturating) on entry, then go to GAP.
REQ-021 GAP SHALL hold all keys at 1 for exactly GAP_CYC cycles, then go to TRACK.
REQ-022 The armed flag SHALL be set on any valid position change and SHALL NOT otherwise be re-set, so that at most one CHANGE press is made per ball position.
REQ-023 Position and direction tracking SHALL continue in PRESS and GAP.
REQ-024 From TRACK, PRESS or GAP, when registered LEDR[1] or LEDR[16] is 1, the FSM SHALL go to DONE with all keys released.
REQ-025 DONE SHALL return to IDLE when EN=0 or when registered LEDR==18'h20201.
REQ-026 When EN=0 in any state, the FSM SHALL go to IDLE next cycle, releasing any key in progress; PRESSES holds its value.
REQ-027 When a game-over condition and EN=0 occur in the same cycle, EN=0 SHALL take priority.
REQ-028 A single 20-bit cycle counter SHALL be used for PRESS/START and GAP timing; it reloads on each state entry, and no wrap-around is permitted.
REQ-029 ENTER_N and CHANGE_N SHALL never be low simultaneously.

Reset
REQ-030 On RESET=0 the block SHALL asynchronously go to IDLE with ENTER_N=1, CHANGE_N=1, STOP_N=1, ACTIVE=0, PRESSES=0, armed=0, dir=UNKNOWN, counter=0 and registered LEDR=0.
REQ-031 When reset is asserted mid-press, the key SHALL release immediately.

Verification (PRESS_CYC=4, GAP_CYC=3, MARGIN=1)
REQ-032 The bench SHALL cover: EN=1, LEDR=18'h20201 -> ENTER_N low exactly 4 cycles starting 2 cycles later, then 3 cycles high, ACTIVE=1.
REQ-033 The bench SHALL cover: ball stepping at bits 9,10,...,15 -> one CHANGE_N low pulse of 4 cycles beginning 2 cycles after bit 15 is seen, PRESSES=1.
REQ-034 The bench SHALL cover: ball held at bit 15 for 50 cycles after a press -> no second press.
REQ-035 The bench SHALL cover: ball reaching bit 16 -> DONE, keys high, ACTIVE=0; then LEDR=18'h20201 -> IDLE and a new ENTER press.
REQ-036 The bench SHALL cover: EN dropped during cycle 2 of a CHANGE press -> CHANGE_N=1 next cycle, IDLE.
REQ-037 The bench SHALL cover: RESET pulsed low mid-GAP with no clock edge -> all outputs at reset values immediately; and 300 presses -> PRESSES=255.
